uart_tx_arb: RTL
================

# uart_tx_arb

Round-robin arbiter and sequencer sharing one UART byte transmitter among NREQ byte-stream requesters. It accepts bytes over per-requester valid/ready handshakes and holds the grant for a whole packet until the byte flagged `last`. It issues one `tx_start` per byte, waits for the transmitter's `tx_done`, and recovers from a hung transmitter via timeout. It sits between the command/status producers and the serial transmitter, mirroring the receive path on the other side of the link.

## Interface
- NREQ, 4: number of requesters (2..8)
- TIMEOUT, 4095: max cycles to wait for `tx_done` before abort
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester byte valid
- req_data  in  8*NREQ  byte of requester i at [8i+7:8i]
- req_last  in  NREQ  byte is the final byte of its packet
- req_ready  out  NREQ  one-hot accept; a byte transfers when valid & ready
- tx_start  out  1  one-cycle pulse: transmitter loads `tx_data`
- tx_data  out  8  byte to send, stable from `tx_start` until `tx_done`
- tx_done  in  1  one-cycle pulse from transmitter: byte fully shifted out
- grant  out  NREQ  one-hot current owner, zero when idle
- busy  out  1  high whenever state != IDLE
- tx_err  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, SEND, WAIT_DONE, HOLD.
- IDLE: if any `req_valid`, pick the first set bit searching upward from `rr_ptr` (wrapping mod NREQ). Register `grant`, go to SEND. Otherwise stay.
- SEND (always exactly one cycle): `req_ready[owner]`=1 (decoded from state and grant). Capture `tx_data`←byte and `last_q`←`req_last[owner]`. Set `tx_start` (registered) and go to WAIT_DONE.
- WAIT_DONE: count cycles and watch `tx_done`:
  - `tx_done` with `last_q`=1: clear `grant`, set `rr_ptr`←owner+1 mod NREQ, go to IDLE.
  - `tx_done` with `last_q`=0 and `req_valid[owner]`=1: go to SEND.
  - `tx_done` with `last_q`=0 and `req_valid[owner]`=0: go to HOLD.
  - Counter reaches TIMEOUT: pulse `tx_err`, release as for a last byte, go to IDLE.
- HOLD: keep the grant and wait for `req_valid[owner]`, then go to SEND. Other requesters are never granted mid-packet.
- Requesters must hold `valid`/`data`/`last` stable until ready. The arbiter ignores valid deassertion except in HOLD.
- `tx_done` is ignored outside WAIT_DONE and in the `tx_start` cycle itself.
- Reset values: state IDLE, `grant`=0, `req_ready`=0, `tx_start`=0, `tx_data`=0x00, `busy`=0, `tx_err`=0, `rr_ptr`=0, timeout counter 0.
- Reset mid-packet: everything returns to reset values the next cycle. The partially sent packet is abandoned with no `tx_err`.
- The timeout counter is wide enough for TIMEOUT ($clog2(TIMEOUT+1)). It clears on entry to WAIT_DONE and never wraps.

## Timing
- Request seen in IDLE at cycle n:
  - n+1: SEND, `req_ready` high, handshake completes.
  - n+2: `tx_start`=1 and `tx_data` valid.
- Earliest `tx_done` is honoured at n+3.
- Back-to-back bytes in a packet: `tx_done` at cycle m → `req_ready` at m+1 → `tx_start` at m+2. Gap is 2 cycles.
- Packet end: `tx_done` at m → IDLE at m+1 → next arbitration decision at m+1, grant at m+2.
- `tx_err` is high in the cycle the state returns to IDLE.
- At most one `req_ready` bit is high in any cycle, and only in SEND.

## Structure
- Shared package `uart_pkg`: state enum (IDLE/SEND/WAIT_DONE/HOLD), byte width constant 8, default NREQ and TIMEOUT.
- One combinational sub-module `uart_rr_pick`:
  - Inputs: NREQ request vector, start pointer.
  - Outputs: one-hot pick and `any` flag.
  - Reused by future arbiters.
- Top holds the FSM, ptr, byte/last registers and timeout counter.

## Test plan
- Single requester 0 sends 0xA5 with last=1:
  - `req_ready[0]` one cycle, `tx_start` 1 cycle later with `tx_data`=0xA5.
  - After `tx_done`: `grant`=0, `busy`=0, `rr_ptr`=1.
- Requesters 1 and 3 valid simultaneously, `rr_ptr`=2:
  - Requester 3 served first, then 1.
  - `rr_ptr` ends at 2.
- Requester 2 sends 3-byte packet 0x11,0x22,0x33 while requester 0 stays valid throughout:
  - Requester 0 never granted until after 0x33's `tx_done`.
  - Inter-byte gap is 2 cycles.
- Requester 1 drops valid after its first non-last byte for 10 cycles: arbiter in HOLD, grant kept, resumes on valid.
- `tx_done` never arrives: `tx_err` pulses exactly TIMEOUT cycles after entering WAIT_DONE, grant released, next requester served.
- `rst` asserted in WAIT_DONE mid-packet: all outputs at reset values the next cycle, no `tx_err`, arbitration restarts from requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter family.
//   state_t     : arbiter FSM states (IDLE / SEND / WAIT_DONE / HOLD)
//   BYTE_W      : width of one transmitted byte
//   DEF_NREQ    : default number of requesters
//   DEF_TIMEOUT : default number of cycles to wait for tx_done
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2,
        HOLD      = 2'd3
    } state_t;

    localparam int BYTE_W      = 8;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 4095;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Bundle of requester handshakes and transmitter control for uart_tx_arb.
//   req_valid/req_data/req_last : per-requester byte offer (byte i at [8i+7:8i])
//   req_ready                   : one-hot accept from the arbiter
//   tx_start/tx_data/tx_done    : transmitter load pulse, byte, completion pulse
//   grant/busy/tx_err           : current owner, activity flag, timeout pulse
// master = requester/transmitter side, slave = arbiter side.
interface uart_tx_arb_if #(
    parameter int NREQ = uart_pkg::DEF_NREQ
);
    import uart_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [BYTE_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ready;
    logic                   tx_start;
    logic [BYTE_W-1:0]      tx_data;
    logic                   tx_done;
    logic [NREQ-1:0]        grant;
    logic                   busy;
    logic                   tx_err;

    modport master (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, tx_start, tx_data, grant, busy, tx_err
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, tx_start, tx_data, grant, busy, tx_err
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector
//   ptr  : index where the upward search starts (wraps mod NREQ)
//   pick : one-hot first requester found at or after ptr, zero if none
//   any  : at least one request present
module uart_rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  pick,
    output logic             any
);

    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    always_comb begin
        int idx;
        idx  = 0;
        pick = '0;
        // Walk from the farthest candidate back toward ptr so the nearest one wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if ((req & (ONE << idx)) != '0) begin
                pick = ONE << idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter/sequencer sharing one UART byte transmitter among NREQ
// requesters. A grant is held for a whole packet (until the byte flagged
// last); each byte is handed over with a one-cycle tx_start and the arbiter
// waits for tx_done, aborting with a tx_err pulse after TIMEOUT cycles.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : uart_tx_arb_if slave modport (handshakes + transmitter control)
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_arb_if.slave bus
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state;
    logic [NREQ-1:0]    grant_q;
    logic [PTR_W-1:0]   rr_ptr;
    logic               tx_start_q;
    logic               tx_err_q;
    logic [BYTE_W-1:0]  tx_data_q;
    logic               last_q;
    logic [CNT_W-1:0]   cnt;

    logic [NREQ-1:0]    pick;
    logic               any;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   ptr_next;
    logic [BYTE_W-1:0]  byte_sel;
    logic               last_sel;
    logic               owner_valid;

    uart_rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .req  (bus.req_valid),
        .ptr  (rr_ptr),
        .pick (pick),
        .any  (any)
    );

    // Owner index and its byte/last/valid, all selected by the one-hot grant.
    always_comb begin
        owner    = '0;
        byte_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                owner    = PTR_W'(i);
                byte_sel = bus.req_data[BYTE_W*i +: BYTE_W];
            end
        end
    end

    assign last_sel    = |(bus.req_last & grant_q);
    assign owner_valid = |(bus.req_valid & grant_q);
    assign ptr_next    = (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_q    <= '0;
            rr_ptr     <= '0;
            tx_start_q <= 1'b0;
            tx_err_q   <= 1'b0;
            tx_data_q  <= '0;
            last_q     <= 1'b0;
            cnt        <= '0;
        end else begin
            tx_start_q <= 1'b0;
            tx_err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        grant_q <= pick;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    tx_data_q  <= byte_sel;
                    last_q     <= last_sel;
                    tx_start_q <= 1'b1;
                    cnt        <= '0;
                    state      <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // tx_done coinciding with our own tx_start belongs to the previous byte.
                    if (bus.tx_done && !tx_start_q) begin
                        if (last_q) begin
                            grant_q <= '0;
                            rr_ptr  <= ptr_next;
                            state   <= IDLE;
                        end else if (owner_valid) begin
                            state <= SEND;
                        end else begin
                            state <= HOLD;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Registered tx_err lands exactly TIMEOUT cycles after entry.
                        tx_err_q <= 1'b1;
                        grant_q  <= '0;
                        rr_ptr   <= ptr_next;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (owner_valid) begin
                        state <= SEND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == SEND) ? grant_q : '0;
    assign bus.grant     = grant_q;
    assign bus.busy      = (state != IDLE);
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_err    = tx_err_q;

endmodule
